rv32i_core: RTL and testbench

//  Self-contained single-cycle RV32I hart with internal unified instruction/data memory and M-mode CSR subset.
//  Top of the simulation design: only clock and reset cross the boundary; the bench preloads memory,

---
 rtl/rv32i_core_if.sv | 14 +
 rtl/rv32i_core.sv | 217 +++++++++++++++++++++
 tb/tb_rv32i_core.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_core_if.sv
// Unified memory bus between the rv32i_core datapath and its internal memory.
// Addresses are carried as word indices; byte lanes are selected by dbe.
interface rv32i_core_if;
    logic [15:0] iword;
    logic [31:0] idata;
    logic [15:0] dword;
    logic [31:0] drdata;
    logic [31:0] dwdata;
    logic [3:0]  dbe;
    logic        dwe;

    modport master (output iword, dword, dwdata, dbe, dwe, input idata, drdata);
    modport slave  (input iword, dword, dwdata, dbe, dwe, output idata, drdata);
endinterface

// File: rtl/rv32i_core.sv
// Single-cycle RV32I hart with an internal unified instruction/data memory
// and a flat 4096-entry M-mode CSR array. Only clk and rst leave the block.

// Unified word memory: two combinational read ports, byte-enabled write port.
// Contents are never reset so a preloaded program survives a reset.
module rv32i_mem #(
    parameter int MEM_WORDS = 65536
) (
    input logic          clk,
    rv32i_core_if.slave  bus
);
    logic [31:0] m [0:MEM_WORDS-1];

    assign bus.idata  = m[bus.iword];
    assign bus.drdata = m[bus.dword];

    // Store path: only the enabled byte lanes change, the rest are preserved
    always_ff @(posedge clk) begin
        if (bus.dwe) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.dbe[b]) m[bus.dword][b*8 +: 8] <= bus.dwdata[b*8 +: 8];
            end
        end
    end
endmodule

module rv32i_core #(
    parameter int          MEM_WORDS = 65536,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input logic clk,
    input logic rst
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MHARTID = 12'hF14;

    rv32i_core_if bus ();
    rv32i_mem #(.MEM_WORDS(MEM_WORDS)) memory (.clk(clk), .bus(bus.slave));

    logic [31:0] pc, nextPc, pcPlus4, instr;
    logic [31:0] rs  [0:31];
    logic [31:0] csr [0:4095];
    logic [6:0]  opcode;
    logic [4:0]  rdIdx, rs1Idx, rs2Idx;
    logic [2:0]  funct3;
    logic [11:0] csrAddr;
    logic [31:0] immI, immS, immB, immU, immJ;
    logic [31:0] rs1Val, rs2Val, addrSum, aluB, aluOut, loadVal, csrOld, csrSrc;
    logic [1:0]  lane;
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;
    logic        takeBranch, rdWe, csrWe, trap;
    logic [31:0] rdData, csrWdata, trapCause;

    assign bus.iword = pc[17:2];
    assign instr     = bus.idata;
    assign opcode    = instr[6:0];
    assign rdIdx     = instr[11:7];
    assign funct3    = instr[14:12];
    assign rs1Idx    = instr[19:15];
    assign rs2Idx    = instr[24:20];
    assign csrAddr   = instr[31:20];
    assign immI      = {{20{instr[31]}}, instr[31:20]};
    assign immS      = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign immB      = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign immU      = {instr[31:12], 12'b0};
    assign immJ      = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign pcPlus4   = pc + 32'd4;
    assign rs1Val    = rs[rs1Idx];
    assign rs2Val    = rs[rs2Idx];
    // One adder serves load/store addressing and the JALR target
    assign addrSum   = rs1Val + ((opcode == OP_STORE) ? immS : immI);
    assign bus.dword = addrSum[17:2];
    assign lane      = addrSum[1:0];
    assign aluB      = (opcode == OP_REG) ? rs2Val : immI;
    assign csrOld    = (csrAddr == CSR_MHARTID) ? 32'h0 : csr[csrAddr];
    assign csrSrc    = funct3[2] ? {27'b0, rs1Idx} : rs1Val;

    // Integer ALU shared by register-register and register-immediate forms
    always_comb begin
        aluOut = 32'h0;
        case (funct3)
            3'd0: aluOut = (opcode == OP_REG && instr[30]) ? rs1Val - aluB : rs1Val + aluB;
            3'd1: aluOut = rs1Val << aluB[4:0];
            3'd2: aluOut = {31'b0, $signed(rs1Val) < $signed(aluB)};
            3'd3: aluOut = {31'b0, rs1Val < aluB};
            3'd4: aluOut = rs1Val ^ aluB;
            3'd5: aluOut = instr[30] ? 32'($signed(rs1Val) >>> aluB[4:0]) : rs1Val >> aluB[4:0];
            3'd6: aluOut = rs1Val | aluB;
            default: aluOut = rs1Val & aluB;
        endcase
    end

    // Branch condition evaluation
    always_comb begin
        takeBranch = 1'b0;
        case (funct3)
            3'd0: takeBranch = (rs1Val == rs2Val);
            3'd1: takeBranch = (rs1Val != rs2Val);
            3'd4: takeBranch = $signed(rs1Val) <  $signed(rs2Val);
            3'd5: takeBranch = $signed(rs1Val) >= $signed(rs2Val);
            3'd6: takeBranch = rs1Val <  rs2Val;
            3'd7: takeBranch = rs1Val >= rs2Val;
            default: takeBranch = 1'b0;
        endcase
    end

    // Load lane extraction and sign/zero extension
    always_comb begin
        loadByte = 8'h0;
        case (lane)
            2'd0: loadByte = bus.drdata[7:0];
            2'd1: loadByte = bus.drdata[15:8];
            2'd2: loadByte = bus.drdata[23:16];
            default: loadByte = bus.drdata[31:24];
        endcase
        loadHalf = lane[1] ? bus.drdata[31:16] : bus.drdata[15:0];
        case (funct3)
            3'd0: loadVal = {{24{loadByte[7]}}, loadByte};
            3'd1: loadVal = {{16{loadHalf[15]}}, loadHalf};
            3'd4: loadVal = {24'b0, loadByte};
            3'd5: loadVal = {16'b0, loadHalf};
            default: loadVal = bus.drdata;
        endcase
    end

    // Main decode: next PC, register/CSR write-back, store strobes and traps
    always_comb begin
        nextPc     = pcPlus4;
        rdWe       = 1'b0;
        rdData     = 32'h0;
        csrWe      = 1'b0;
        csrWdata   = 32'h0;
        trap       = 1'b0;
        trapCause  = 32'h0;
        bus.dwe    = 1'b0;
        bus.dbe    = 4'b0;
        bus.dwdata = 32'h0;
        case (opcode)
            OP_LUI:    begin rdWe = 1'b1; rdData = immU; end
            OP_AUIPC:  begin rdWe = 1'b1; rdData = pc + immU; end
            OP_JAL:    begin rdWe = 1'b1; rdData = pcPlus4; nextPc = pc + immJ; end
            OP_JALR:   begin rdWe = 1'b1; rdData = pcPlus4; nextPc = addrSum & ~32'h1; end
            OP_BRANCH: if (takeBranch) nextPc = pc + immB;
            OP_LOAD:   begin rdWe = 1'b1; rdData = loadVal; end
            OP_IMM, OP_REG: begin rdWe = 1'b1; rdData = aluOut; end
            OP_STORE: begin
                bus.dwe = !rst;
                case (funct3[1:0])
                    2'b00: begin bus.dbe = 4'b0001 << lane; bus.dwdata = {4{rs2Val[7:0]}}; end
                    2'b01: begin bus.dbe = lane[1] ? 4'b1100 : 4'b0011; bus.dwdata = {2{rs2Val[15:0]}}; end
                    default: begin bus.dbe = 4'b1111; bus.dwdata = rs2Val; end
                endcase
            end
            OP_SYSTEM: begin
                if (funct3 == 3'd0) begin
                    case (csrAddr)
                        12'h000: begin trap = 1'b1; trapCause = 32'd11; end
                        12'h001: begin trap = 1'b1; trapCause = 32'd3; end
                        12'h302: nextPc = csr[CSR_MEPC];
                        default: ;
                    endcase
                    if (trap) nextPc = csr[CSR_MTVEC] & ~32'h3;
                end else if (funct3 != 3'd4) begin
                    rdWe  = 1'b1;
                    rdData = csrOld;
                    csrWe = (funct3[1:0] == 2'b01) || (rs1Idx != 5'd0);
                    case (funct3[1:0])
                        2'b01:   csrWdata = csrSrc;
                        2'b10:   csrWdata = csrOld | csrSrc;
                        default: csrWdata = csrOld & ~csrSrc;
                    endcase
                end
            end
            default: ;
        endcase
    end

    // Program counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc <= RESET_PC;
        else     pc <= nextPc;
    end

    // Integer register file; x0 is never written so it always reads zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rs[i] <= 32'h0;
        end else if (rdWe && rdIdx != 5'd0) begin
            rs[rdIdx] <= rdData;
        end
    end

    // CSR array, including trap entry bookkeeping of mepc/mcause
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4096; i++) csr[i] <= 32'h0;
        end else if (trap) begin
            csr[CSR_MEPC]   <= pc;
            csr[CSR_MCAUSE] <= trapCause;
        end else if (csrWe && csrAddr != CSR_MHARTID) begin
            csr[csrAddr] <= csrWdata;
        end
    end
endmodule

// File: tb/tb_rv32i_core.sv
// Self-checking bench for rv32i_core: assembles small programs straight into
// dut.memory.m, runs a fixed number of cycles and inspects pc/rs/csr.
module tb_rv32i_core;
    logic clk = 1'b0;
    logic rst = 1'b1;

    rv32i_core #(.MEM_WORDS(65536), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst));

    always #5 clk = ~clk;

    localparam logic [6:0]  OPIMM = 7'b0010011;
    localparam logic [6:0]  SYS   = 7'b1110011;
    localparam logic [6:0]  LD    = 7'b0000011;
    localparam logic [31:0] JSELF = 32'h0000006F;

    typedef enum int {
        K_ADD, K_SUB, K_SLL, K_SLT, K_SLTU, K_XOR, K_SRL, K_SRA, K_OR, K_AND,
        K_ADDI, K_SLTI, K_SLTIU, K_XORI, K_ORI, K_ANDI, K_SLLI, K_SRLI, K_SRAI
    } aluKind_e;

    typedef struct {
        aluKind_e    kind;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;
    int progLen = 0;
    vec_t fixedVecs [14];

    function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] encS(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] encB(input logic [12:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [2:0] kindF3(input aluKind_e k);
        case (k)
            K_ADD, K_SUB, K_ADDI: return 3'd0;
            K_SLL, K_SLLI:        return 3'd1;
            K_SLT, K_SLTI:        return 3'd2;
            K_SLTU, K_SLTIU:      return 3'd3;
            K_XOR, K_XORI:        return 3'd4;
            K_SRL, K_SRA, K_SRLI, K_SRAI: return 3'd5;
            K_OR, K_ORI:          return 3'd6;
            default:              return 3'd7;
        endcase
    endfunction

    // Assemble "op x5, x1, x2" or "opi x5, x1, imm" for the given kind
    function automatic logic [31:0] encAlu(input aluKind_e k, input logic [31:0] b);
        logic [6:0] f7;
        f7 = (k == K_SUB || k == K_SRA) ? 7'b0100000 : 7'b0;
        if (k < K_ADDI) return {f7, 5'd2, 5'd1, kindF3(k), 5'd5, 7'b0110011};
        if (k == K_SLLI || k == K_SRLI) return encI({7'b0, b[4:0]}, 5'd1, kindF3(k), 5'd5, OPIMM);
        if (k == K_SRAI) return encI({7'b0100000, b[4:0]}, 5'd1, kindF3(k), 5'd5, OPIMM);
        return encI(b[11:0], 5'd1, kindF3(k), 5'd5, OPIMM);
    endfunction

    // Reference model straight from the ISA definitions
    function automatic logic [31:0] refAlu(input aluKind_e k, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b & 32'd31);
        case (k)
            K_ADD, K_ADDI:   return a + b;
            K_SUB:           return a + ~b + 32'd1;
            K_SLL, K_SLLI:   return a << sh;
            K_SLT, K_SLTI:   return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            K_SLTU, K_SLTIU: return (a < b) ? 32'd1 : 32'd0;
            K_XOR, K_XORI:   return a ^ b;
            K_SRL, K_SRLI:   return a >> sh;
            K_SRA, K_SRAI:   return (a >> sh) | ((a & 32'h8000_0000) != 0 ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            K_OR, K_ORI:     return a | b;
            default:         return a & b;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %08h, expected %08h", name, actual, expected);
        end
    endtask

    task automatic beginProgram();
        rst = 1'b1;
        #1;
        for (int i = 0; i < 128; i++) dut.memory.m[i] = 32'h0;
        progLen = 0;
    endtask

    task automatic emit(input logic [31:0] w);
        dut.memory.m[progLen] = w;
        progLen++;
    endtask

    task automatic emitLi(input logic [4:0] rd, input logic [31:0] val);
        logic [31:0] hi;
        hi = val + 32'h800;
        emit({hi[31:12], rd, 7'b0110111});
        emit(encI(val[11:0], rd, 3'd0, rd, OPIMM));
    endtask

    task automatic run(input int n);
        @(negedge clk);
        rst = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input aluKind_e k, input logic [31:0] a, input logic [31:0] b);
        beginProgram();
        emitLi(5'd1, a);
        emitLi(5'd2, b);
        emit(encAlu(k, b));
        emit(JSELF);
        run(8);
    endtask

    initial begin
        aluKind_e k;
        logic [31:0] a, b, r;
        int nz;

        fixedVecs[0]  = '{K_SLTIU, 32'h0000_000F, 32'hFFFF_FFFF, 32'h1};
        fixedVecs[1]  = '{K_SLTIU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
        fixedVecs[2]  = '{K_SLTIU, 32'h0,         32'h0,         32'h0};
        fixedVecs[3]  = '{K_SUB,   32'd5,         32'd7,         32'hFFFF_FFFE};
        fixedVecs[4]  = '{K_SRA,   32'h8000_0000, 32'd4,         32'hF800_0000};
        fixedVecs[5]  = '{K_SRAI,  32'h8000_0010, 32'd4,         32'hF800_0001};
        fixedVecs[6]  = '{K_SLT,   32'hFFFF_FFFF, 32'd1,         32'h1};
        fixedVecs[7]  = '{K_SLTU,  32'hFFFF_FFFF, 32'd1,         32'h0};
        fixedVecs[8]  = '{K_SLL,   32'd1,         32'd33,        32'd2};
        fixedVecs[9]  = '{K_ADD,   32'hFFFF_FFFF, 32'd1,         32'h0};
        fixedVecs[10] = '{K_SRLI,  32'h8000_0000, 32'd31,        32'h1};
        fixedVecs[11] = '{K_XORI,  32'h0F0F_0F0F, 32'hFFFF_FFFF, 32'hF0F0_F0F0};
        fixedVecs[12] = '{K_ANDI,  32'h1234_5678, 32'h0000_07FF, 32'h0000_0678};
        fixedVecs[13] = '{K_ORI,   32'h0,         32'hFFFF_F800, 32'hFFFF_F800};

        // Reset state
        #2;
        checkOutput("reset_pc", dut.pc, 32'h0);
        checkOutput("reset_x3", dut.rs[3], 32'h0);

        // Table-driven ALU vectors
        for (int i = 0; i < 14; i++) begin
            applyStimulus(fixedVecs[i].kind, fixedVecs[i].a, fixedVecs[i].b);
            checkOutput($sformatf("table%0d_%s", i, fixedVecs[i].kind.name()), dut.rs[5], fixedVecs[i].exp);
        end

        // Randomized ALU vectors against the reference model
        for (int i = 0; i < 40; i++) begin
            k = aluKind_e'($urandom_range(0, 18));
            a = $urandom;
            r = $urandom;
            if (k == K_SLLI || k == K_SRLI || k == K_SRAI) b = r & 32'd31;
            else if (k >= K_ADDI) b = {{20{r[11]}}, r[11:0]};
            else b = r;
            applyStimulus(k, a, b);
            checkOutput($sformatf("rand%0d_%s", i, k.name()), dut.rs[5], refAlu(k, a, b));
        end

        // Minimal pass-flag program: pc parks on the self-jump
        beginProgram();
        emit(encI(12'd1, 5'd0, 3'd0, 5'd3, OPIMM));
        emit(JSELF);
        run(10);
        checkOutput("gp_flag", dut.rs[3], 32'h1);
        checkOutput("selfjump_pc", dut.pc, 32'h4);

        // Sub-word loads and stores
        beginProgram();
        emitLi(5'd1, 32'h1122_3344);
        emit(encI(12'h100, 5'd0, 3'd0, 5'd2, OPIMM));
        emit(encS(12'd0, 5'd1, 5'd2, 3'd2));
        emit(encI(12'd3, 5'd2, 3'd0, 5'd10, LD));
        emit(encI(12'd3, 5'd2, 3'd4, 5'd11, LD));
        emit(encI(12'd2, 5'd2, 3'd1, 5'd12, LD));
        emit(encI(12'd2, 5'd2, 3'd5, 5'd13, LD));
        emit(encI(12'h0AA, 5'd0, 3'd0, 5'd4, OPIMM));
        emit(encS(12'd1, 5'd4, 5'd2, 3'd0));
        emit(encI(12'd0, 5'd2, 3'd2, 5'd14, LD));
        emit(encI(12'd1, 5'd2, 3'd0, 5'd15, LD));
        emit(encI(12'd0, 5'd2, 3'd5, 5'd16, LD));
        emit(encI(12'd0, 5'd2, 3'd1, 5'd17, LD));
        emit(JSELF);
        run(20);
        checkOutput("lb_103", dut.rs[10], 32'h11);
        checkOutput("lbu_103", dut.rs[11], 32'h11);
        checkOutput("lh_102", dut.rs[12], 32'h1122);
        checkOutput("lhu_102", dut.rs[13], 32'h1122);
        checkOutput("lw_after_sb", dut.rs[14], 32'h1122_AA44);
        checkOutput("mem_after_sb", dut.memory.m[64], 32'h1122_AA44);
        checkOutput("lb_101_sext", dut.rs[15], 32'hFFFF_FFAA);
        checkOutput("lhu_100", dut.rs[16], 32'h0000_AA44);
        checkOutput("lh_100_sext", dut.rs[17], 32'hFFFF_AA44);

        // Branches, JALR alignment and the x0 sink
        beginProgram();
        emit(encI(12'hFFF, 5'd0, 3'd0, 5'd1, OPIMM));
        emit(encI(12'd1, 5'd0, 3'd0, 5'd2, OPIMM));
        emit(encB(13'd8, 5'd2, 5'd1, 3'd4));
        emit(encI(12'd1, 5'd0, 3'd0, 5'd10, OPIMM));
        emit(encB(13'd8, 5'd2, 5'd1, 3'd6));
        emit(encI(12'd1, 5'd0, 3'd0, 5'd11, OPIMM));
        emit(encB(13'd8, 5'd2, 5'd1, 3'd1));
        emit(encI(12'd1, 5'd0, 3'd0, 5'd12, OPIMM));
        emit(encI(12'h02D, 5'd0, 3'd0, 5'd15, OPIMM));
        emit(encI(12'd0, 5'd15, 3'd0, 5'd14, 7'b1100111));
        emit(encI(12'd1, 5'd0, 3'd0, 5'd16, OPIMM));
        emit(JSELF);
        run(20);
        checkOutput("blt_taken", dut.rs[10], 32'h0);
        checkOutput("bltu_not_taken", dut.rs[11], 32'h1);
        checkOutput("bne_taken", dut.rs[12], 32'h0);
        checkOutput("jalr_link", dut.rs[14], 32'h28);
        checkOutput("jalr_skip", dut.rs[16], 32'h0);
        checkOutput("jalr_pc", dut.pc, 32'h2C);

        // ECALL into handler at mtvec, then MRET back to mepc
        beginProgram();
        emit(encI(12'h040, 5'd0, 3'd0, 5'd1, OPIMM));
        emit(encI(12'h305, 5'd1, 3'd1, 5'd0, SYS));
        emit(encI(12'd5, 5'd0, 3'd0, 5'd0, OPIMM));
        for (int i = 0; i < 5; i++) emit(encI(12'd0, 5'd0, 3'd0, 5'd0, OPIMM));
        emit(32'h0000_0073);
        dut.memory.m[16] = encI(12'h342, 5'd0, 3'd2, 5'd6, SYS);
        dut.memory.m[17] = 32'h3020_0073;
        run(8);
        checkOutput("pre_ecall_pc", dut.pc, 32'h20);
        checkOutput("x0_stays_zero", dut.rs[0], 32'h0);
        checkOutput("mtvec", dut.csr[12'h305], 32'h40);
        run(1);
        checkOutput("ecall_pc", dut.pc, 32'h40);
        checkOutput("ecall_mepc", dut.csr[12'h341], 32'h20);
        checkOutput("ecall_mcause", dut.csr[12'h342], 32'd11);
        run(1);
        checkOutput("csrrs_read", dut.rs[6], 32'd11);
        run(1);
        checkOutput("mret_pc", dut.pc, 32'h20);

        // Immediate CSR forms, mhartid, EBREAK with mtvec left at zero
        beginProgram();
        emit(encI(12'h340, 5'd31, 3'd5, 5'd0, SYS));
        emit(encI(12'h340, 5'd5, 3'd7, 5'd5, SYS));
        emit(encI(12'h340, 5'd0, 3'd6, 5'd6, SYS));
        emit(encI(12'hF14, 5'd0, 3'd2, 5'd7, SYS));
        emit(32'h0010_0073);
        run(5);
        checkOutput("csrrci_old", dut.rs[5], 32'd31);
        checkOutput("csrrsi_old", dut.rs[6], 32'd26);
        checkOutput("mscratch", dut.csr[12'h340], 32'd26);
        checkOutput("mhartid", dut.rs[7], 32'h0);
        checkOutput("ebreak_pc", dut.pc, 32'h0);
        checkOutput("ebreak_mepc", dut.csr[12'h341], 32'h10);
        checkOutput("ebreak_mcause", dut.csr[12'h342], 32'd3);

        // Asynchronous reset in the middle of a run
        run(3);
        #2;
        rst = 1'b1;
        #1;
        nz = 0;
        for (int i = 0; i < 32; i++) if (dut.rs[i] != 32'h0) nz++;
        checkOutput("midreset_pc", dut.pc, 32'h0);
        checkOutput("midreset_nonzero_regs", 32'(nz), 32'h0);
        checkOutput("midreset_csr", dut.csr[12'h340], 32'h0);
        checkOutput("midreset_mem_kept", dut.memory.m[0], encI(12'h340, 5'd31, 3'd5, 5'd0, SYS));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
